// File: rtl/bus_pkg.sv
// Shared bus definitions: FSM encoding, cmd bit positions, widths and defaults.
package bus_pkg;

  localparam int unsigned ADDR_W          = 10;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned CMD_W           = 2;
  localparam int unsigned CMD_READ        = 0;
  localparam int unsigned CMD_WRITE       = 1;
  localparam int unsigned TIMEOUT_DEFAULT = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } bus_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  // One-hot engine command for a given direction.
  function automatic logic [CMD_W-1:0] cmd_for(input logic write);
    cmd_for = write ? CMD_W'(1 << CMD_WRITE) : CMD_W'(1 << CMD_READ);
  endfunction

endpackage

// File: rtl/bus_cycle_arbiter_rr_arbiter2.sv
// Two-way round-robin picker; remembers which requester was served last.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic       pick_c
);

  logic last_q;

  // Last-served register; requester 1 after reset so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else if (update) begin
      last_q <= served;
    end
  end

  // Lone requester wins outright; on a tie the one not served last wins.
  always_comb begin
    case (req)
      2'b01:   pick_c = 1'b0;
      2'b10:   pick_c = 1'b1;
      default: pick_c = ~last_q;
    endcase
  end

endmodule

// File: rtl/bus_cycle_arbiter.sv
// Arbitrates two requesters onto a single ISA-style bus engine, one cycle at a time.
module bus_cycle_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        req_write,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [CMD_W-1:0]  cmd,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              cycle_done_n
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  // Firing one count early makes the total cmd-active time exactly TIMEOUT clocks.
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(TIMEOUT - 1);

  bus_state_e        state_q;
  bus_state_e        state_next;
  logic              pick;
  bus_req_t          cur_req;
  logic              winner_q;
  logic              dir_q;
  logic              dir_next;
  logic [CNT_W-1:0]  tcnt_q;
  logic              grant;
  logic              done_hit;
  logic              timeout_hit;
  logic [CMD_W-1:0]  cmd_d;
  logic [1:0]        ack_d;
  logic              err_d;
  logic [DATA_W-1:0] rdata_d;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .update (state_q == ST_DONE),
    .served (winner_q),
    .pick_c (pick)
  );

  // Payload of the requester the picker currently favours.
  assign cur_req = pick ? {req_write[1], req_addr1, req_wdata1}
                        : {req_write[0], req_addr0, req_wdata0};

  assign grant       = (state_q == ST_IDLE) && (req != 2'b00);
  assign done_hit    = (state_q == ST_WAIT) && !cycle_done_n;
  assign timeout_hit = (state_q == ST_WAIT) && cycle_done_n && (tcnt_q >= CNT_FIRE);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state logic; completion strobe only counts while waiting.
  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_IDLE:  if (grant) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (done_hit || timeout_hit) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output next-values, computed from the upcoming state so outputs can be registered.
  always_comb begin
    cmd_d    = '0;
    ack_d    = 2'b00;
    err_d    = 1'b0;
    rdata_d  = rdata;
    dir_next = grant ? cur_req.write : dir_q;
    if ((state_next == ST_ISSUE) || (state_next == ST_WAIT)) begin
      cmd_d = cmd_for(dir_next);
    end
    if (done_hit || timeout_hit) begin
      ack_d = winner_q ? 2'b10 : 2'b01;
    end
    if (timeout_hit) begin
      err_d   = 1'b1;
      rdata_d = 8'hFF;
    end else if (done_hit && !dir_q) begin
      rdata_d = bus_rdata;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cmd   <= '0;
      ack   <= 2'b00;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      cmd   <= cmd_d;
      ack   <= ack_d;
      err   <= err_d;
      rdata <= rdata_d;
    end
  end

  // Transaction latches, loaded only when a grant is made from IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus_addr  <= '0;
      bus_wdata <= '0;
      dir_q     <= 1'b0;
      winner_q  <= 1'b0;
    end else if (grant) begin
      bus_addr  <= cur_req.addr;
      bus_wdata <= cur_req.wdata;
      dir_q     <= cur_req.write;
      winner_q  <= pick;
    end
  end

  // Saturating timeout counter, cleared at grant and running through ISSUE and WAIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tcnt_q <= '0;
    end else if (grant) begin
      tcnt_q <= '0;
    end else if (((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && (tcnt_q != CNT_MAX)) begin
      tcnt_q <= tcnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Self-checking bench for bus_cycle_arbiter with a transaction-level reference model.
module tb_bus_cycle_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req, req_write;
  logic [9:0] req_addr0, req_addr1;
  logic [7:0] req_wdata0, req_wdata1;
  logic [1:0] ack;
  logic       err;
  logic [7:0] rdata;
  logic [1:0] cmd;
  logic [9:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       cycle_done_n;

  int checks   = 0;
  int failures = 0;

  // Reference model state: last served requester and the held read data.
  int         m_last;
  logic [7:0] m_rdata;

  // Observations from one bus transaction.
  bit         o_got;
  int         o_first, o_cnt;
  logic [1:0] o_cmd, o_ack, o_cmd_end;
  logic [9:0] o_addr, o_addr_end;
  logic [7:0] o_wdata, o_rdata;
  logic       o_err;

  bus_cycle_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_write(req_write),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .ack(ack), .err(err), .rdata(rdata), .cmd(cmd),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .cycle_done_n(cycle_done_n)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(input logic [1:0] r, input int last);
    if (r == 2'b11) return 1 - last;
    if (r == 2'b10) return 1;
    return 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset   = 1'b1;
    m_last  = 1;
    m_rdata = 8'h00;
  endtask

  // Plays the bus engine for one transaction: strobes done on the lat-th cmd clock (lat=0: never).
  task automatic run_cycle(input int lat, input logic [7:0] rd, input bit drop);
    bit seen;
    seen = 0;
    o_got = 0; o_first = -1; o_cnt = 0; o_cmd = '0; o_addr = '0; o_wdata = '0;
    o_ack = '0; o_err = 1'b0; o_rdata = '0; o_cmd_end = '1; o_addr_end = '0;
    for (int i = 0; i < 200 && !o_got; i++) begin
      @(negedge clk);
      if (ack !== 2'b00) begin
        o_got = 1; o_ack = ack; o_err = err; o_rdata = rdata;
        o_cmd_end = cmd; o_addr_end = bus_addr;
      end else if (cmd !== 2'b00) begin
        if (!seen) begin
          seen = 1; o_first = i; o_cmd = cmd; o_addr = bus_addr; o_wdata = bus_wdata;
        end
        o_cnt++;
        if (drop && o_cnt == 2) begin
          req = 2'b00; req_addr0 = ~req_addr0; req_addr1 = ~req_addr1; req_write = ~req_write;
        end
        cycle_done_n = !(lat > 0 && o_cnt == lat);
        bus_rdata    = cycle_done_n ? ~rd : rd;
      end else begin
        cycle_done_n = 1'b1;
      end
    end
    cycle_done_n = 1'b1;
  endtask

  task automatic test_reset();
    req = 2'b11; req_write = 2'b11;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cmd !== 2'b00) begin failures++; $display("FAIL reset_cmd got=%b exp=00", cmd); end
    checks++; if (ack !== 2'b00) begin failures++; $display("FAIL reset_ack got=%b exp=00", ack); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
    checks++; if (bus_addr !== 10'h000) begin failures++; $display("FAIL reset_addr got=%h exp=000", bus_addr); end
    checks++; if (bus_wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata got=%h exp=00", bus_wdata); end
    req = 2'b00;
    reset = 1'b1; m_last = 1; m_rdata = 8'h00;
  endtask

  task automatic test_write();
    req = 2'b01; req_write = 2'b01; req_addr0 = 10'h22C; req_wdata0 = 8'h5A;
    req_addr1 = 10'h111; req_wdata1 = 8'h11;
    run_cycle(6, 8'h33, 0);
    req = 2'b00; m_last = 0;
    checks++; if (!o_got) begin failures++; $display("FAIL write_ack_seen got=0 exp=1"); end
    checks++; if (o_cmd !== 2'b10) begin failures++; $display("FAIL write_cmd got=%b exp=10", o_cmd); end
    checks++; if (o_cnt != 6) begin failures++; $display("FAIL write_cmd_len got=%0d exp=6", o_cnt); end
    checks++; if (o_addr !== 10'h22C) begin failures++; $display("FAIL write_addr got=%h exp=22c", o_addr); end
    checks++; if (o_wdata !== 8'h5A) begin failures++; $display("FAIL write_wdata got=%h exp=5a", o_wdata); end
    checks++; if (o_ack !== 2'b01) begin failures++; $display("FAIL write_ack got=%b exp=01", o_ack); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL write_err got=%b exp=0", o_err); end
    checks++; if (o_rdata !== m_rdata) begin failures++; $display("FAIL write_rdata_held got=%h exp=%h", o_rdata, m_rdata); end
    checks++; if (o_cmd_end !== 2'b00) begin failures++; $display("FAIL write_cmd_end got=%b exp=00", o_cmd_end); end
    @(negedge clk);
    checks++; if (ack !== 2'b00) begin failures++; $display("FAIL write_ack_pulse got=%b exp=00", ack); end
  endtask

  task automatic test_read();
    req = 2'b10; req_write = 2'b00; req_addr1 = 10'h22A; req_addr0 = 10'h3FF;
    run_cycle(4, 8'hAA, 0);
    req = 2'b00; m_last = 1; m_rdata = 8'hAA;
    checks++; if (o_cmd !== 2'b01) begin failures++; $display("FAIL read_cmd got=%b exp=01", o_cmd); end
    checks++; if (o_addr !== 10'h22A) begin failures++; $display("FAIL read_addr got=%h exp=22a", o_addr); end
    checks++; if (o_ack !== 2'b10) begin failures++; $display("FAIL read_ack got=%b exp=10", o_ack); end
    checks++; if (o_rdata !== 8'hAA) begin failures++; $display("FAIL read_rdata got=%h exp=aa", o_rdata); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL read_err got=%b exp=0", o_err); end
  endtask

  task automatic test_tie();
    int w;
    logic [1:0] e_ack;
    req = 2'b11; req_write = 2'b10;
    req_addr0 = 10'h0A0; req_addr1 = 10'h1B1; req_wdata0 = 8'h01; req_wdata1 = 8'h02;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      w = rr_pick(req, m_last);
      e_ack = (w == 1) ? 2'b10 : 2'b01;
      run_cycle(3, 8'h5C, 0);
      m_last = w;
      if (w == 0) m_rdata = 8'h5C;
      checks++; if (o_ack !== e_ack) begin failures++; $display("FAIL tie_grant%0d got=%b exp=%b", k, o_ack, e_ack); end
      if (k > 0) begin
        checks++; if (o_first != 1) begin failures++; $display("FAIL tie_spacing%0d got=%0d exp=1", k, o_first); end
      end
    end
    req = 2'b00;
  endtask

  task automatic test_timeout();
    req = 2'b01; req_write = 2'b00; req_addr0 = 10'h300;
    run_cycle(0, 8'h12, 0);
    req = 2'b00; m_last = 0; m_rdata = 8'hFF;
    checks++; if (o_cnt != 31) begin failures++; $display("FAIL timeout_len got=%0d exp=31", o_cnt); end
    checks++; if (o_ack !== 2'b01) begin failures++; $display("FAIL timeout_ack got=%b exp=01", o_ack); end
    checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", o_err); end
    checks++; if (o_rdata !== 8'hFF) begin failures++; $display("FAIL timeout_rdata got=%h exp=ff", o_rdata); end
    checks++; if (o_cmd_end !== 2'b00) begin failures++; $display("FAIL timeout_cmd got=%b exp=00", o_cmd_end); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL timeout_err_pulse got=%b exp=0", err); end
  endtask

  task automatic test_reset_mid();
    bit ok, spur;
    ok = 0; spur = 0;
    req = 2'b01; req_write = 2'b00; req_addr0 = 10'h2F0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (cmd !== 2'b00) ok = 1;
    end
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_start got=no_cmd exp=cmd"); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (cmd !== 2'b00) begin failures++; $display("FAIL rstmid_cmd got=%b exp=00", cmd); end
    checks++; if (ack !== 2'b00) begin failures++; $display("FAIL rstmid_ack got=%b exp=00", ack); end
    req = 2'b00; reset = 1'b1; m_last = 1; m_rdata = 8'h00;
    repeat (6) begin
      @(negedge clk);
      if (ack !== 2'b00 || cmd !== 2'b00) spur = 1;
    end
    checks++; if (spur) begin failures++; $display("FAIL rstmid_quiet got=activity exp=none"); end
    req = 2'b10; req_write = 2'b10; req_addr1 = 10'h155; req_wdata1 = 8'hC3;
    run_cycle(3, 8'h00, 0);
    req = 2'b00; m_last = 1;
    checks++; if (o_ack !== 2'b10) begin failures++; $display("FAIL rstmid_after_ack got=%b exp=10", o_ack); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL rstmid_after_err got=%b exp=0", o_err); end
    checks++; if (o_addr !== 10'h155) begin failures++; $display("FAIL rstmid_after_addr got=%h exp=155", o_addr); end
  endtask

  task automatic test_glitch();
    bit spur;
    spur = 0;
    req = 2'b00;
    cycle_done_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (cmd !== 2'b00 || ack !== 2'b00 || err !== 1'b0) spur = 1;
    end
    cycle_done_n = 1'b1;
    checks++; if (spur) begin failures++; $display("FAIL glitch_idle got=activity exp=none"); end
    req = 2'b10; req_write = 2'b10; req_addr1 = 10'h0C5; req_wdata1 = 8'h77;
    run_cycle(5, 8'h00, 1);
    m_last = 1;
    checks++; if (o_ack !== 2'b10) begin failures++; $display("FAIL glitch_drop_ack got=%b exp=10", o_ack); end
    checks++; if (o_cnt != 5) begin failures++; $display("FAIL glitch_drop_len got=%0d exp=5", o_cnt); end
    checks++; if (o_addr_end !== 10'h0C5) begin failures++; $display("FAIL glitch_drop_addr got=%h exp=0c5", o_addr_end); end
    req = 2'b01; req_write = 2'b00; req_addr0 = 10'h077;
    run_cycle(1, 8'h44, 0);
    req = 2'b00; m_last = 0; m_rdata = 8'hFF;
    checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL glitch_issue_err got=%b exp=1", o_err); end
    checks++; if (o_cnt != 31) begin failures++; $display("FAIL glitch_issue_len got=%0d exp=31", o_cnt); end
  endtask

  task automatic test_random();
    int w, lat;
    bit drop, to;
    logic       e_write;
    logic [1:0] e_ack, e_cmd;
    logic [9:0] e_addr;
    logic [7:0] e_wdata, rd;
    for (int k = 0; k < 24; k++) begin
      req        = 2'($urandom_range(1, 3));
      req_write  = 2'($urandom_range(0, 3));
      req_addr0  = 10'($urandom); req_addr1  = 10'($urandom);
      req_wdata0 = 8'($urandom);  req_wdata1 = 8'($urandom);
      rd         = 8'($urandom);
      lat        = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 9));
      drop       = 1'($urandom_range(0, 1));
      to         = (lat == 0);
      w          = rr_pick(req, m_last);
      e_write    = req_write[w];
      e_addr     = (w == 1) ? req_addr1 : req_addr0;
      e_wdata    = (w == 1) ? req_wdata1 : req_wdata0;
      e_ack      = (w == 1) ? 2'b10 : 2'b01;
      e_cmd      = e_write ? 2'b10 : 2'b01;
      run_cycle(lat, rd, drop);
      m_last = w;
      if (to) m_rdata = 8'hFF;
      else if (!e_write) m_rdata = rd;
      checks++; if (o_ack !== e_ack) begin failures++; $display("FAIL rnd%0d_ack got=%b exp=%b", k, o_ack, e_ack); end
      checks++; if (o_cmd !== e_cmd) begin failures++; $display("FAIL rnd%0d_cmd got=%b exp=%b", k, o_cmd, e_cmd); end
      checks++; if (o_cnt != (to ? 31 : lat)) begin failures++; $display("FAIL rnd%0d_len got=%0d exp=%0d", k, o_cnt, to ? 31 : lat); end
      checks++; if (o_addr !== e_addr || o_addr_end !== e_addr) begin failures++; $display("FAIL rnd%0d_addr got=%h/%h exp=%h", k, o_addr, o_addr_end, e_addr); end
      checks++; if (o_wdata !== e_wdata) begin failures++; $display("FAIL rnd%0d_wdata got=%h exp=%h", k, o_wdata, e_wdata); end
      checks++; if (o_err !== to) begin failures++; $display("FAIL rnd%0d_err got=%b exp=%b", k, o_err, to); end
      checks++; if (o_rdata !== m_rdata) begin failures++; $display("FAIL rnd%0d_rdata got=%h exp=%h", k, o_rdata, m_rdata); end
      checks++; if (o_cmd_end !== 2'b00) begin failures++; $display("FAIL rnd%0d_cmd_end got=%b exp=00", k, o_cmd_end); end
    end
    req = 2'b00;
  endtask

  initial begin
    reset = 1'b0; req = 2'b00; req_write = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    bus_rdata = '0; cycle_done_n = 1'b1;
    m_last = 1; m_rdata = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_tie();
    test_timeout();
    test_reset_mid();
    test_glitch();
    test_random();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=no_finish exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
